// File: rtl/pred_hit_tracker_pkg.sv
// Shared BPU definitions for the predictor hit tracker and predictor selector users.
// Optional feature macro: PRED_TAG_CHECK_EN (per-entry PC tag check on resolve).
package pred_hit_tracker_pkg;

    localparam int unsigned BPU_PRED_NUM  = 2;
    localparam int unsigned BPU_DEPTH_DEF = 4;
    localparam int unsigned BPU_PTR_W_DEF = 2;
    localparam int unsigned BPU_TAG_W_DEF = 8;

    // Entry layout: predictor guesses in the low bits, optional tag above them
    localparam int unsigned ENT_PRED_LSB = 0;
    localparam int unsigned ENT_TAG_LSB  = BPU_PRED_NUM;

    typedef logic [BPU_PRED_NUM-1:0] pred_vec_t;

    // Bit i set when predictor i guessed the actual outcome
    function automatic pred_vec_t pred_hits(input pred_vec_t pred, input logic taken);
        return pred ~^ {BPU_PRED_NUM{taken}};
    endfunction

endpackage

// File: rtl/pred_hist_fifo.sv
// Generic in-order sync FIFO with occupancy count and a clear that keeps the pop.
// Caller guarantees no push while full unless a pop happens in the same cycle.
module pred_hist_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty_c,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_nxt;

    // Clear drops everything younger than the (possibly just popped) head
    always_comb begin
        rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        if (clear) begin
            wr_ptr_nxt = rd_ptr_nxt;
            count_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == (PTR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty_c = (count == '0);

endmodule

// File: rtl/pred_hit_tracker.sv
// Tracks both predictors' guesses per in-flight branch and reports per-predictor hits at resolve.
// Optional feature macro: PRED_TAG_CHECK_EN (store PC tag, drop hit and flag error on mismatch).
module pred_hit_tracker
    import pred_hit_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = BPU_DEPTH_DEF,
    parameter int unsigned PTR_W = BPU_PTR_W_DEF,
    parameter int unsigned TAG_W = BPU_TAG_W_DEF
) (
    input  logic                    in_Clk,
    input  logic                    in_Rst,
    input  logic                    in_push,
    input  logic [BPU_PRED_NUM-1:0] in_pred,
    input  logic [TAG_W-1:0]        in_push_tag,
    input  logic                    in_resolve,
    input  logic                    in_taken,
    input  logic [TAG_W-1:0]        in_res_tag,
    input  logic                    in_flush,
    output logic [BPU_PRED_NUM-1:0] out_hit,
    output logic                    out_hit_valid,
    output logic                    out_full,
    output logic [PTR_W:0]          out_count,
    output logic                    out_err
);

`ifdef PRED_TAG_CHECK_EN
    localparam int unsigned ENTRY_W = BPU_PRED_NUM + TAG_W;
`else
    localparam int unsigned ENTRY_W = BPU_PRED_NUM;
`endif

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_W:0]     fifo_count;
    logic               res_ok;
    logic               push_ok;
    logic               tag_ok;
    pred_vec_t          rd_pred;

    // A pop always frees a slot, so a push into a full queue is legal alongside it
    assign res_ok  = in_resolve & ~fifo_empty;
    assign push_ok = in_push & ~in_flush & (~fifo_full | res_ok);
    assign rd_pred = rd_entry[ENT_PRED_LSB +: BPU_PRED_NUM];

`ifdef PRED_TAG_CHECK_EN
    assign wr_entry = {in_push_tag, in_pred};
    assign tag_ok   = (rd_entry[ENT_TAG_LSB +: TAG_W] == in_res_tag);
`else
    logic tag_unused;
    assign wr_entry   = in_pred;
    assign tag_ok     = 1'b1;
    assign tag_unused = ^{in_push_tag, in_res_tag};
`endif

    pred_hist_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (in_Clk),
        .rst     (in_Rst),
        .push    (push_ok),
        .pop     (res_ok),
        .clear   (in_flush),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    // Hit result and strobes; out_hit holds its last value between valid strobes
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            out_hit       <= '0;
            out_hit_valid <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            out_hit_valid <= res_ok & tag_ok;
            out_err       <= (in_resolve & fifo_empty) | (res_ok & ~tag_ok);
            if (res_ok & tag_ok) begin
                out_hit <= pred_hits(rd_pred, in_taken);
            end
        end
    end

    assign out_full  = fifo_full;
    assign out_count = fifo_count;

endmodule

// File: tb/tb_pred_hit_tracker.sv
// Directed self-checking bench for pred_hit_tracker (DEPTH=4), hand-computed expectations.
// Honours PRED_TAG_CHECK_EN when defined for both DUT and bench.
module tb_pred_hit_tracker;

    logic       clk;
    logic       rst;
    logic       in_push;
    logic [1:0] in_pred;
    logic [7:0] in_push_tag;
    logic       in_resolve;
    logic       in_taken;
    logic [7:0] in_res_tag;
    logic       in_flush;
    logic [1:0] out_hit;
    logic       out_hit_valid;
    logic       out_full;
    logic [2:0] out_count;
    logic       out_err;

    int tests_run = 0;
    int tests_failed = 0;

    pred_hit_tracker #(
        .DEPTH (4),
        .PTR_W (2),
        .TAG_W (8)
    ) dut (
        .in_Clk        (clk),
        .in_Rst        (rst),
        .in_push       (in_push),
        .in_pred       (in_pred),
        .in_push_tag   (in_push_tag),
        .in_resolve    (in_resolve),
        .in_taken      (in_taken),
        .in_res_tag    (in_res_tag),
        .in_flush      (in_flush),
        .out_hit       (out_hit),
        .out_hit_valid (out_hit_valid),
        .out_full      (out_full),
        .out_count     (out_count),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, then settle just past the edge with inputs idle
    task automatic cyc(input logic p, input logic [1:0] pr, input logic [7:0] pt,
                       input logic r, input logic t, input logic [7:0] rt, input logic f);
        in_push     = p;
        in_pred     = pr;
        in_push_tag = pt;
        in_resolve  = r;
        in_taken    = t;
        in_res_tag  = rt;
        in_flush    = f;
        @(posedge clk);
        #1;
        in_push    = 1'b0;
        in_resolve = 1'b0;
        in_flush   = 1'b0;
        in_taken   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] hit, input logic v,
                           input logic full, input logic [2:0] cnt, input logic err);
        chk({tag, ".hit"},   32'(out_hit),       32'(hit));
        chk({tag, ".valid"}, 32'(out_hit_valid), 32'(v));
        chk({tag, ".full"},  32'(out_full),      32'(full));
        chk({tag, ".count"}, 32'(out_count),     32'(cnt));
        chk({tag, ".err"},   32'(out_err),       32'(err));
    endtask

    initial begin
        rst = 1'b1;
        in_push = 1'b0; in_pred = 2'b00; in_push_tag = 8'h00;
        in_resolve = 1'b0; in_taken = 1'b0; in_res_tag = 8'h00; in_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // 1: single push then resolve
        cyc(1, 2'b10, 8'h11, 0, 0, 8'h00, 0);
        chk_out("t1_push", 2'b00, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h11, 0);
        chk_out("t1_res", 2'b10, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc(0, 2'b00, 8'h00, 0, 0, 8'h00, 0);
        chk_out("t1_idle", 2'b10, 1'b0, 1'b0, 3'd0, 1'b0);

        // 2: fill, overflow drop, push+resolve while full, drain in order
        cyc(1, 2'b01, 8'h21, 0, 0, 8'h00, 0);
        cyc(1, 2'b11, 8'h22, 0, 0, 8'h00, 0);
        cyc(1, 2'b00, 8'h23, 0, 0, 8'h00, 0);
        chk_out("t2_three", 2'b10, 1'b0, 1'b0, 3'd3, 1'b0);
        cyc(1, 2'b10, 8'h24, 0, 0, 8'h00, 0);
        chk_out("t2_full", 2'b10, 1'b0, 1'b1, 3'd4, 1'b0);
        cyc(1, 2'b11, 8'h25, 0, 0, 8'h00, 0);
        chk_out("t2_drop", 2'b10, 1'b0, 1'b1, 3'd4, 1'b0);
        cyc(1, 2'b01, 8'h26, 1, 1, 8'h21, 0);
        chk_out("t2_pushpop", 2'b01, 1'b1, 1'b1, 3'd4, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 0, 8'h22, 0);
        chk_out("t2_d1", 2'b00, 1'b1, 1'b0, 3'd3, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 0, 8'h23, 0);
        chk_out("t2_d2", 2'b11, 1'b1, 1'b0, 3'd2, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h24, 0);
        chk_out("t2_d3", 2'b10, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h26, 0);
        chk_out("t2_d4", 2'b01, 1'b1, 1'b0, 3'd0, 1'b0);

        // 3: resolve on empty
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h00, 0);
        chk_out("t3_empty", 2'b01, 1'b0, 1'b0, 3'd0, 1'b1);
        cyc(0, 2'b00, 8'h00, 0, 0, 8'h00, 0);
        chk_out("t3_idle", 2'b01, 1'b0, 1'b0, 3'd0, 1'b0);

        // 4: resolve + flush + push in one cycle with three entries held
        cyc(1, 2'b10, 8'h31, 0, 0, 8'h00, 0);
        cyc(1, 2'b01, 8'h32, 0, 0, 8'h00, 0);
        cyc(1, 2'b11, 8'h33, 0, 0, 8'h00, 0);
        chk_out("t4_three", 2'b01, 1'b0, 1'b0, 3'd3, 1'b0);
        cyc(1, 2'b00, 8'h34, 1, 1, 8'h31, 1);
        chk_out("t4_flush", 2'b10, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc(0, 2'b00, 8'h00, 1, 0, 8'h34, 0);
        chk_out("t4_absent", 2'b10, 1'b0, 1'b0, 3'd0, 1'b1);
        cyc(1, 2'b01, 8'h35, 0, 0, 8'h00, 0);
        cyc(0, 2'b00, 8'h00, 1, 0, 8'h35, 0);
        chk_out("t4_after", 2'b10, 1'b1, 1'b0, 3'd0, 1'b0);

        // 5: tag mismatch, then matching tag
        cyc(1, 2'b11, 8'h3C, 0, 0, 8'h00, 0);
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h3D, 0);
`ifdef PRED_TAG_CHECK_EN
        chk_out("t5_mismatch", 2'b10, 1'b0, 1'b0, 3'd0, 1'b1);
`else
        chk_out("t5_notag", 2'b11, 1'b1, 1'b0, 3'd0, 1'b0);
`endif
        cyc(1, 2'b01, 8'h3C, 0, 0, 8'h00, 0);
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h3C, 0);
        chk_out("t5_match", 2'b01, 1'b1, 1'b0, 3'd0, 1'b0);

        // 6: reset mid-cycle with entries held and a pending strobe
        cyc(1, 2'b11, 8'h41, 0, 0, 8'h00, 0);
        cyc(1, 2'b00, 8'h42, 0, 0, 8'h00, 0);
        cyc(1, 2'b10, 8'h43, 0, 0, 8'h00, 0);
        cyc(0, 2'b00, 8'h00, 1, 0, 8'h41, 0);
        chk_out("t6_pre", 2'b00, 1'b1, 1'b0, 3'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_rst", 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 2'b00, 8'h00, 1, 1, 8'h42, 0);
        chk_out("t6_post", 2'b00, 1'b0, 1'b0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
